n64_vinfo_ctrl: RTL and testbench



---
 rtl/n64_vinfo_ctrl.sv | 173 +++++++++++++++++
 tb/tb_n64_vinfo_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_vinfo_ctrl.sv
// n64_vinfo_ctrl
// Per-field video-mode controller for the N64 video input path. Follows the
// nDSYNC word framing to produce the colour-slot counter, counts lines per
// field, qualifies PAL/NTSC and 480i decisions over two agreeing fields, and
// latches the user deblur settings at every field boundary.
module n64_vinfo_ctrl #(
  parameter int LINE_W = 10,
  parameter int PAL_TH = 290
) (
  input  logic       VCLK,
  input  logic       RST,
  input  logic       nDSYNC,
  input  logic [3:0] D_i,
  input  logic       nForceDeBlur_i,
  input  logic       nDeBlurMan_i,
  output logic [5:0] deblurparams_o,
  output logic       locked_o,
  output logic       new_frame_o
);

  typedef enum logic [1:0] {
    SEEK,
    MEAS,
    ACQ,
    LOCKED
  } state_t;

  localparam logic [LINE_W-1:0] LineMax = '1;
  localparam logic [LINE_W-1:0] PalTh   = LINE_W'(PAL_TH);

  logic [1:0]        r_dataCnt;
  logic [3:0]        r_syncPre;
  logic [LINE_W-1:0] r_lineCnt;
  logic [LINE_W-1:0] r_prevCnt;
  state_t            r_state;
  logic              r_haveCand;
  logic [1:0]        r_candReg;
  logic              r_vmode;
  logic              r_n64480i;
  logic              r_nForceDeBlur;
  logic              r_nDeBlurMan;
  logic              r_locked;
  logic              r_newFrame;

  logic              w_fb;
  logic              w_he;
  logic              w_sat;
  logic [1:0]        w_cand;
  logic              w_unused;

  // Field boundary is a falling nVSYNC, line edge a falling nHSYNC, both
  // judged only on sync words against the previous sync word.
  assign w_fb  = !nDSYNC && r_syncPre[3] && !D_i[3];
  assign w_he  = !nDSYNC && r_syncPre[1] && !D_i[1];
  assign w_sat = (r_lineCnt == LineMax);

  // Candidate {vmode, 480i}: long fields are PAL, and interlaced sources
  // alternate between odd and even field lengths.
  assign w_cand = {(r_lineCnt >= PalTh), (r_lineCnt[0] != r_prevCnt[0])};

  // nCLAMP and nCSYNC are sampled along with the rest of the sync word but
  // nothing in this block depends on them.
  assign w_unused = &{1'b0, r_syncPre[2], r_syncPre[0]};

  // Colour-slot counter: a sync word means the next word is R (slot 01);
  // without sync words the counter simply keeps wrapping.
  always_ff @(posedge VCLK) begin
    if (RST) begin
      r_dataCnt <= 2'b00;
    end else if (!nDSYNC) begin
      r_dataCnt <= 2'b01;
    end else begin
      r_dataCnt <= r_dataCnt + 2'd1;
    end
  end

  // Sync-word history and line counting; an HE landing on the FB word is the
  // first line of the new field.
  always_ff @(posedge VCLK) begin
    if (RST) begin
      r_syncPre <= 4'hF;
      r_lineCnt <= '0;
      r_prevCnt <= '0;
    end else begin
      if (!nDSYNC) begin
        r_syncPre <= D_i;
      end
      if (w_fb) begin
        r_prevCnt <= r_lineCnt;
        r_lineCnt <= w_he ? LINE_W'(1) : '0;
      end else if (w_he && !w_sat) begin
        r_lineCnt <= r_lineCnt + 1'b1;
      end
    end
  end

  // User settings are only allowed to change at field boundaries; the
  // new-frame pulse marks the cycle after each boundary.
  always_ff @(posedge VCLK) begin
    if (RST) begin
      r_nForceDeBlur <= 1'b1;
      r_nDeBlurMan   <= 1'b1;
      r_newFrame     <= 1'b0;
    end else begin
      r_newFrame <= w_fb;
      if (w_fb) begin
        r_nForceDeBlur <= nForceDeBlur_i;
        r_nDeBlurMan   <= nDeBlurMan_i;
      end
    end
  end

  // Mode qualification: a decision is applied only after two consecutive
  // fields agree; a runaway line count drops back to SEEK immediately while
  // the applied mode is held.
  always_ff @(posedge VCLK) begin
    if (RST) begin
      r_state    <= SEEK;
      r_haveCand <= 1'b0;
      r_candReg  <= 2'b00;
      r_vmode    <= 1'b0;
      r_n64480i  <= 1'b1;
      r_locked   <= 1'b0;
    end else if (w_sat && (r_state != SEEK)) begin
      r_state    <= SEEK;
      r_haveCand <= 1'b0;
      r_locked   <= 1'b0;
    end else if (w_fb) begin
      case (r_state)
        SEEK: begin
          r_state    <= MEAS;
          r_haveCand <= 1'b0;
          r_locked   <= 1'b0;
        end
        MEAS: begin
          r_state  <= ACQ;
          r_locked <= 1'b0;
        end
        ACQ: begin
          if (!r_haveCand) begin
            r_candReg  <= w_cand;
            r_haveCand <= 1'b1;
          end else if (w_cand == r_candReg) begin
            r_vmode   <= w_cand[1];
            r_n64480i <= w_cand[0];
            r_state   <= LOCKED;
            r_locked  <= 1'b1;
          end else begin
            r_candReg <= w_cand;
          end
        end
        LOCKED: begin
          if (w_cand != {r_vmode, r_n64480i}) begin
            r_state    <= ACQ;
            r_candReg  <= w_cand;
            r_haveCand <= 1'b1;
            r_locked   <= 1'b0;
          end
        end
        default: begin
          r_state    <= SEEK;
          r_haveCand <= 1'b0;
          r_locked   <= 1'b0;
        end
      endcase
    end
  end

  assign deblurparams_o = {r_dataCnt, r_vmode, r_n64480i, r_nForceDeBlur, r_nDeBlurMan};
  assign locked_o       = r_locked;
  assign new_frame_o    = r_newFrame;

endmodule

// File: tb/tb_n64_vinfo_ctrl.sv
// tb_n64_vinfo_ctrl
// Drives synthetic N64 sync-word streams (one line = nHSYNC high word then
// nHSYNC low word, one field boundary = a single nVSYNC low word) and checks
// the controller against a field-level reference model.
module tb_n64_vinfo_ctrl;

  localparam int LineW = 10;
  localparam int PalTh = 290;

  logic       VCLK = 1'b0;
  logic       RST = 1'b1;
  logic       nDSYNC = 1'b1;
  logic [3:0] D_i = 4'hF;
  logic       nForceDeBlur_i = 1'b1;
  logic       nDeBlurMan_i = 1'b1;
  logic [5:0] deblurparams_o;
  logic       locked_o;
  logic       new_frame_o;

  int total = 0;
  int bad = 0;

  // Reference model: field-level view of qualification. A field's candidate
  // is {length >= PalTh, length parity differs from previous field}; the
  // controller is locked after a field whose candidate equals the previous
  // field's candidate (third full field onward after a (re)start).
  int       mFbIdx;
  int       mPrevLen;
  bit [1:0] mPrevCand;
  bit       mLocked;
  bit       mVmode;
  bit       m480i;
  bit       mForce;
  bit       mMan;
  int       tbLastLen;

  n64_vinfo_ctrl #(
    .LINE_W(LineW),
    .PAL_TH(PalTh)
  ) dut (
    .VCLK(VCLK),
    .RST(RST),
    .nDSYNC(nDSYNC),
    .D_i(D_i),
    .nForceDeBlur_i(nForceDeBlur_i),
    .nDeBlurMan_i(nDeBlurMan_i),
    .deblurparams_o(deblurparams_o),
    .locked_o(locked_o),
    .new_frame_o(new_frame_o)
  );

  always #5 VCLK = ~VCLK;

  task automatic modelReset();
    mFbIdx    = 0;
    mPrevLen  = 0;
    mPrevCand = 2'b00;
    mLocked   = 1'b0;
    mVmode    = 1'b0;
    m480i     = 1'b1;
    mForce    = 1'b1;
    mMan      = 1'b1;
  endtask

  task automatic modelFb(input int len);
    bit [1:0] cand;
    int n;
    mForce = nForceDeBlur_i;
    mMan   = nDeBlurMan_i;
    mFbIdx++;
    n = mFbIdx - 1;
    if (n >= 2) begin
      cand = {(len >= PalTh), ((len % 2) != (mPrevLen % 2))};
      mLocked = (n >= 3) && (cand == mPrevCand);
      if (mLocked) {mVmode, m480i} = cand;
      mPrevCand = cand;
    end
    if (n >= 1) mPrevLen = len;
  endtask

  // One bus word per cycle, driven on the falling edge; returns at the next
  // falling edge so outputs are sampled half a cycle after the rising edge.
  task automatic applyStimulus(input logic nd, input logic [3:0] d);
    nDSYNC = nd;
    D_i    = d;
    @(negedge VCLK);
  endtask

  task automatic gapWords();
    repeat ($urandom_range(0, 2)) applyStimulus(1'b1, 4'($urandom));
  endtask

  task automatic pulseReset();
    RST = 1'b1;
    nForceDeBlur_i = 1'b1;
    nDeBlurMan_i = 1'b1;
    applyStimulus(1'b1, 4'hF);
    applyStimulus(1'b1, 4'hF);
    RST = 1'b0;
    modelReset();
    tbLastLen = 0;
  endtask

  task automatic startField(input bit coincide);
    if (coincide) applyStimulus(1'b0, 4'b1111);
    modelFb(tbLastLen);
    applyStimulus(1'b0, coincide ? 4'b0100 : 4'b0111);
    total++;
    if (locked_o !== mLocked) begin
      bad++;
      $display("[TB] FAIL locked_fb%0d got=%b want=%b", mFbIdx, locked_o, mLocked);
    end
    total++;
    if (deblurparams_o[3:0] !== {mVmode, m480i, mForce, mMan}) begin
      bad++;
      $display("[TB] FAIL mode_fb%0d got=%b want=%b", mFbIdx, deblurparams_o[3:0], {mVmode, m480i, mForce, mMan});
    end
    total++;
    if (new_frame_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL new_frame_fb%0d got=%b want=1", mFbIdx, new_frame_o);
    end
  endtask

  task automatic sendField(input int len, input bit coincide, input bit gaps, input bit toggle);
    int first;
    int toggleAt;
    startField(coincide);
    first = coincide ? 2 : 1;
    toggleAt = len / 2;
    for (int i = first; i <= len; i++) begin
      if (i != 1) begin
        applyStimulus(1'b0, 4'b1111);
        if (gaps) gapWords();
      end
      applyStimulus(1'b0, 4'b1100);
      if (i == first) begin
        total++;
        if (new_frame_o !== 1'b0) begin
          bad++;
          $display("[TB] FAIL new_frame_low got=%b want=0", new_frame_o);
        end
      end
      if (gaps) gapWords();
      if (toggle && (i == toggleAt)) begin
        nDeBlurMan_i = ~nDeBlurMan_i;
        nForceDeBlur_i = 1'($urandom);
        applyStimulus(1'b1, 4'($urandom));
        total++;
        if (deblurparams_o[1:0] !== {mForce, mMan}) begin
          bad++;
          $display("[TB] FAIL settings_midfield got=%b want=%b", deblurparams_o[1:0], {mForce, mMan});
        end
      end
    end
    tbLastLen = len;
  endtask

  task automatic test_reset();
    pulseReset();
    total++;
    if (deblurparams_o !== 6'b000111) begin
      bad++;
      $display("[TB] FAIL reset_bundle got=%b want=000111", deblurparams_o);
    end
    total++;
    if (locked_o !== 1'b0 || new_frame_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags got=%b%b want=00", locked_o, new_frame_o);
    end
  endtask

  task automatic test_data_cnt();
    int expCnt;
    for (int r = 0; r < 9; r++) begin
      applyStimulus(1'b0, 4'hF);
      expCnt = 1;
      total++;
      if (deblurparams_o[5:4] !== 2'(expCnt)) begin
        bad++;
        $display("[TB] FAIL data_cnt_sync got=%0d want=%0d", deblurparams_o[5:4], expCnt);
      end
      // Rounds 0-2 regular framing, round 3 drops one sync word, rest random.
      repeat ((r < 3) ? 3 : (r == 3) ? 7 : $urandom_range(0, 6)) begin
        applyStimulus(1'b1, 4'($urandom));
        expCnt = (expCnt + 1) % 4;
        total++;
        if (deblurparams_o[5:4] !== 2'(expCnt)) begin
          bad++;
          $display("[TB] FAIL data_cnt_data got=%0d want=%0d", deblurparams_o[5:4], expCnt);
        end
      end
    end
  endtask

  task automatic test_ntsc240p();
    pulseReset();
    for (int k = 0; k < 4; k++) sendField(263, 1'b0, 1'b0, 1'b0);
    total++;
    if ({locked_o, deblurparams_o[3:2]} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL ntsc240p_lock got=%b want=100", {locked_o, deblurparams_o[3:2]});
    end
  endtask

  task automatic test_ntsc480i();
    pulseReset();
    sendField(262, 1'b0, 1'b0, 1'b0);
    sendField(263, 1'b0, 1'b0, 1'b0);
    sendField(262, 1'b0, 1'b0, 1'b0);
    sendField(263, 1'b0, 1'b0, 1'b0);
    total++;
    if ({locked_o, deblurparams_o[3:2]} !== 3'b101) begin
      bad++;
      $display("[TB] FAIL ntsc480i_lock got=%b want=101", {locked_o, deblurparams_o[3:2]});
    end
    sendField(263, 1'b0, 1'b0, 1'b0);
    sendField(263, 1'b0, 1'b0, 1'b0);
    total++;
    if ({locked_o, deblurparams_o[3:2]} !== 3'b001) begin
      bad++;
      $display("[TB] FAIL ntsc480i_drop got=%b want=001", {locked_o, deblurparams_o[3:2]});
    end
    sendField(263, 1'b0, 1'b0, 1'b0);
    total++;
    if ({locked_o, deblurparams_o[3:2]} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL ntsc480i_relock got=%b want=100", {locked_o, deblurparams_o[3:2]});
    end
  endtask

  task automatic test_pal();
    pulseReset();
    for (int k = 0; k < 4; k++) sendField(313, 1'b0, 1'b0, 1'b0);
    total++;
    if ({locked_o, deblurparams_o[3:2]} !== 3'b110) begin
      bad++;
      $display("[TB] FAIL pal_lock got=%b want=110", {locked_o, deblurparams_o[3:2]});
    end
    for (int k = 0; k < 3; k++) sendField(289, 1'b0, 1'b0, 1'b0);
    total++;
    if ({locked_o, deblurparams_o[3:2]} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL pal_289 got=%b want=100", {locked_o, deblurparams_o[3:2]});
    end
    for (int k = 0; k < 4; k++) sendField(290, 1'b0, 1'b0, 1'b0);
    total++;
    if ({locked_o, deblurparams_o[3:2]} !== 3'b110) begin
      bad++;
      $display("[TB] FAIL pal_290 got=%b want=110", {locked_o, deblurparams_o[3:2]});
    end
  endtask

  task automatic test_coincide();
    pulseReset();
    for (int k = 0; k < 5; k++) sendField(290, bit'(k % 2), 1'b0, 1'b0);
    total++;
    if ({locked_o, deblurparams_o[3:2]} !== 3'b110) begin
      bad++;
      $display("[TB] FAIL coincide_lock got=%b want=110", {locked_o, deblurparams_o[3:2]});
    end
  endtask

  task automatic test_settings();
    pulseReset();
    for (int k = 0; k < 4; k++) sendField(263, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_saturation();
    pulseReset();
    for (int k = 0; k < 4; k++) sendField(263, 1'b0, 1'b0, 1'b0);
    startField(1'b0);
    applyStimulus(1'b0, 4'b1100);
    for (int i = 2; i <= 1023; i++) begin
      applyStimulus(1'b0, 4'b1111);
      applyStimulus(1'b0, 4'b1100);
    end
    total++;
    if (locked_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sat_before got=%b want=1", locked_o);
    end
    applyStimulus(1'b0, 4'b1111);
    mLocked = 1'b0;
    mFbIdx = 0;
    total++;
    if ({locked_o, deblurparams_o[3:2]} !== {mLocked, mVmode, m480i}) begin
      bad++;
      $display("[TB] FAIL sat_drop got=%b want=%b", {locked_o, deblurparams_o[3:2]}, {mLocked, mVmode, m480i});
    end
    applyStimulus(1'b0, 4'b1100);
    for (int i = 1025; i <= 1030; i++) begin
      applyStimulus(1'b0, 4'b1111);
      applyStimulus(1'b0, 4'b1100);
    end
    tbLastLen = 1030;
    for (int k = 0; k < 4; k++) sendField(263, 1'b0, 1'b0, 1'b0);
    total++;
    if (locked_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sat_relock got=%b want=1", locked_o);
    end
  endtask

  task automatic test_random();
    int len;
    pulseReset();
    for (int f = 0; f < 10; f++) begin
      case ($urandom_range(0, 3))
        0:       len = 262;
        1:       len = 263;
        2:       len = 289 + $urandom_range(0, 1);
        default: len = $urandom_range(240, 330);
      endcase
      sendField(len, bit'($urandom_range(0, 1)), 1'b1, 1'b1);
    end
  endtask

  task automatic test_rst_midfield();
    pulseReset();
    nForceDeBlur_i = 1'b0;
    nDeBlurMan_i = 1'b0;
    for (int k = 0; k < 5; k++) sendField(263, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    applyStimulus(1'b0, 4'b0111);
    RST = 1'b0;
    modelReset();
    tbLastLen = 0;
    total++;
    if ({deblurparams_o, locked_o, new_frame_o} !== 8'b00011100) begin
      bad++;
      $display("[TB] FAIL rst_midfield got=%b want=00011100", {deblurparams_o, locked_o, new_frame_o});
    end
    nForceDeBlur_i = 1'b1;
    nDeBlurMan_i = 1'b1;
  endtask

  initial begin
    modelReset();
    tbLastLen = 0;
    test_reset();
    test_data_cnt();
    test_ntsc240p();
    test_ntsc480i();
    test_pal();
    test_coincide();
    test_settings();
    test_saturation();
    test_random();
    test_rst_midfield();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
